bitstream_buffer_ctrl: RTL

BITSTREAM_BUFFER_CTRL -- requirements
Module: bitstream_buffer_ctrl

---
 rtl/bitstream_buffer_ctrl_pkg.sv | 15 +
 rtl/bitstream_buffer_ctrl_if.sv | 43 ++++
 rtl/bitstream_buffer_ctrl_lzc.sv | 17 +
 rtl/bitstream_buffer_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/bitstream_buffer_ctrl_pkg.sv
// Shared definitions for the bitstream buffer: FSM encodings and buffer geometry.
// The optional byte-align feature is enabled by defining BS_BYTE_ALIGN_EN.
package bitstream_buffer_ctrl_pkg;

  localparam int BS_STATE_W = 2;
  localparam logic [BS_STATE_W-1:0] BS_IDLE = 2'd0;
  localparam logic [BS_STATE_W-1:0] BS_FILL = 2'd1;
  localparam logic [BS_STATE_W-1:0] BS_RUN  = 2'd2;

  localparam int BS_BUF_W  = 64;
  localparam int BS_RUN_W  = 48;
  localparam int BS_WORD_W = 16;
  localparam int BS_CNT_W  = 7;

endpackage

// File: rtl/bitstream_buffer_ctrl_if.sv
// Bus bundle between the bitstream source/parser and the buffer controller.
// byte_align exists only when BS_BYTE_ALIGN_EN is defined.
interface bitstream_buffer_ctrl_if;
  import bitstream_buffer_ctrl_pkg::*;

  logic                 start;
  logic [BS_WORD_W-1:0] mem_data;
  logic                 mem_valid;
  logic                 mem_rd;
  logic                 consume_en;
  logic [4:0]           consume_len;
  logic [15:0]          BitStream_buffer_output;
  logic [31:0]          BitStream_buffer_output_ex32;
  logic [3:0]           heading_one_pos;
  logic                 buffer_valid;
  logic                 underflow_err;
`ifdef BS_BYTE_ALIGN_EN
  logic                 byte_align;

  modport master (
    output start, mem_data, mem_valid, consume_en, consume_len, byte_align,
    input  mem_rd, BitStream_buffer_output, BitStream_buffer_output_ex32,
           heading_one_pos, buffer_valid, underflow_err
  );
  modport slave (
    input  start, mem_data, mem_valid, consume_en, consume_len, byte_align,
    output mem_rd, BitStream_buffer_output, BitStream_buffer_output_ex32,
           heading_one_pos, buffer_valid, underflow_err
  );
`else
  modport master (
    output start, mem_data, mem_valid, consume_en, consume_len,
    input  mem_rd, BitStream_buffer_output, BitStream_buffer_output_ex32,
           heading_one_pos, buffer_valid, underflow_err
  );
  modport slave (
    input  start, mem_data, mem_valid, consume_en, consume_len,
    output mem_rd, BitStream_buffer_output, BitStream_buffer_output_ex32,
           heading_one_pos, buffer_valid, underflow_err
  );
`endif

endinterface

// File: rtl/bitstream_buffer_ctrl_lzc.sv
// Leading-zero counter over the 16-bit output window, saturating at 15.
module bs_leading_zero_cnt
  import bitstream_buffer_ctrl_pkg::*;
(
  input  logic [BS_WORD_W-1:0] data_i,
  output logic [3:0]           lz_o
);

  // Higher set bits overwrite lower ones; all-zero and 0x0001 both give 15.
  always_comb begin
    lz_o = 4'd15;
    for (int unsigned i = 0; i < 16; i++) begin
      if (data_i[i]) lz_o = 4'(15 - i);
    end
  end

endmodule

// File: rtl/bitstream_buffer_ctrl.sv
// Bitstream buffer: 64-bit left-aligned shift register refilled 16 bits at a time.
// Define BS_BYTE_ALIGN_EN to add the byte_align input and consumed-bit offset counter.
module bitstream_buffer_ctrl
  import bitstream_buffer_ctrl_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  bitstream_buffer_ctrl_if.slave bus
);

  logic [BS_STATE_W-1:0] state_q, state_d;
  logic [BS_BUF_W-1:0]   buf_q, buf_d;
  logic [BS_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [4:0]            eff_len;
  logic [BS_CNT_W-1:0]   cnt_after;
  logic                  buf_valid;
  logic                  accept;
  logic [BS_BUF_W-1:0]   word_ext;

  assign buf_valid = (cnt_q >= BS_CNT_W'(BS_RUN_W)) && (state_q == BS_RUN);

`ifdef BS_BYTE_ALIGN_EN
  logic [2:0] ofs_q, ofs_d;
  logic [2:0] align_len;

  assign align_len = 3'd0 - ofs_q;

  always_comb begin
    eff_len = '0;
    if (buf_valid) begin
      if (bus.byte_align)      eff_len = {2'b00, align_len};
      else if (bus.consume_en) eff_len = bus.consume_len;
    end
  end

  always_comb begin
    ofs_d = ofs_q + eff_len[2:0];
    if (bus.start) ofs_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ofs_q <= '0;
    else       ofs_q <= ofs_d;
  end
`else
  always_comb begin
    eff_len = '0;
    if (bus.consume_en && buf_valid) eff_len = bus.consume_len;
  end
`endif

  assign cnt_after  = cnt_q - {2'b00, eff_len};
  assign bus.mem_rd = (state_q != BS_IDLE) && !bus.start &&
                      (cnt_after <= BS_CNT_W'(BS_RUN_W));
  assign accept     = bus.mem_rd && bus.mem_valid;
  // New word lands directly behind the bits that survive this cycle's consume.
  assign word_ext   = {bus.mem_data, {(BS_BUF_W-BS_WORD_W){1'b0}}} >> cnt_after;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (bus.start) begin
      state_d = BS_FILL;
      buf_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      buf_d = buf_q << eff_len;
      cnt_d = cnt_after;
      if (accept) begin
        buf_d = buf_d | word_ext;
        cnt_d = cnt_after + BS_CNT_W'(BS_WORD_W);
      end
      if (bus.consume_en && !buf_valid) err_d = 1'b1;
      case (state_q)
        BS_FILL: if (cnt_d >= BS_CNT_W'(BS_RUN_W)) state_d = BS_RUN;
        BS_RUN:  if (cnt_d <  BS_CNT_W'(BS_RUN_W)) state_d = BS_FILL;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BS_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.BitStream_buffer_output      = buf_q[BS_BUF_W-1 -: 16];
  assign bus.BitStream_buffer_output_ex32 = buf_q[BS_BUF_W-17 -: 32];
  assign bus.buffer_valid                 = buf_valid;
  assign bus.underflow_err                = err_q;

  bs_leading_zero_cnt u_lzc (
    .data_i (buf_q[BS_BUF_W-1 -: 16]),
    .lz_o   (bus.heading_one_pos)
  );

endmodule
